gpio_controller: RTL and testbench
==================================

# gpio_controller

Parametrised, memory-mapped general-purpose I/O block with CHANNELS independent pins. It sits on the data load/store channels beside the system memory's IO region and replaces the fixed single-bit output and input cells. Each pin gets a configurable input synchroniser, output and output-enable registers, and rising/falling edge detection with sticky pending bits. It raises a registered interrupt request with the vector of the lowest-numbered active channel.

## Interface
Parameters:
- CHANNELS, 8, number of GPIO pins (legal 1..32)
- SYNC_STAGES, 2, depth of the input synchroniser (legal >= 2)

Ports:
- clk_i  in  1  single system clock, all logic on rising edge
- rst_i  in  1  reset, synchronous and active-high
- store_request_i  in  1  store strobe, one cycle per access
- store_address_i  in  6  byte offset of register, bits [1:0] ignored
- store_data_i  in  32  write data
- store_done_o  out  1  store acknowledge
- load_request_i  in  1  load strobe, one cycle per access
- load_address_i  in  6  byte offset of register, bits [1:0] ignored
- load_data_o  out  32  read data
- load_valid_o  out  1  read data valid
- gpio_i  in  CHANNELS  asynchronous external inputs
- gpio_o  out  CHANNELS  output values
- gpio_oe_o  out  CHANNELS  output enables, 1 = drive
- interrupt_o  out  1  interrupt request, level
- interrupt_vector_o  out  8  index of the lowest active channel; 8'hFF when none

## Operation
- Accesses are full 32-bit words only. Register bits at or above CHANNELS read 0 and ignore writes.
- Register map (byte offset):
  - 0x00 DATA_IN (RO): synchronised input values.
  - 0x04 DATA_OUT (RW): drives gpio_o.
  - 0x08 OUT_EN (RW): drives gpio_oe_o.
  - 0x0C INT_EN (RW).
  - 0x10 INT_RISE (RW).
  - 0x14 INT_FALL (RW).
  - 0x18 INT_PEND (read; write-1-to-clear).
  - 0x1C OUT_SET (WO): DATA_OUT |= data.
  - 0x20 OUT_CLR (WO): DATA_OUT &= ~data.
  - 0x24..0x3C are unmapped: reads return 0, writes are ignored but still acknowledged.
- Synchroniser: per-pin shift chain of SYNC_STAGES flops; its last stage is DATA_IN. A `prev` register holds DATA_IN delayed by one cycle.
- Edge terms: rise = DATA_IN & ~prev; fall = ~DATA_IN & prev.
- Pending update each cycle: INT_PEND <= (INT_PEND & ~w1c_mask) | (rise & INT_RISE) | (fall & INT_FALL).
  - Pending bits latch regardless of INT_EN.
  - If a new edge and a W1C hit the same bit in the same cycle, set wins.
- Interrupt: active = INT_PEND & INT_EN.
  - interrupt_o <= |active.
  - interrupt_vector_o <= index of the lowest set bit of active, or 8'hFF when active is 0.
- A load and a store may occur in the same cycle and are both served. The load returns the value held before the store (read-before-write). Reading INT_PEND never clears it.

## Timing
- Reset values: every register, synchroniser stage and `prev` are 0. Outputs reset to gpio_o=0, gpio_oe_o=0, load_data_o=0, load_valid_o=0, store_done_o=0, interrupt_o=0, interrupt_vector_o=8'hFF.
- Reset asserted mid-access: the access is dropped, no done or valid is produced, and all state returns to reset values on that edge.
- Store: register updates on the edge that samples store_request_i. gpio_o and gpio_oe_o reflect the new value in the following cycle. store_done_o pulses high for exactly 1 cycle, in the cycle after the request.
- Load: load_data_o is registered. load_valid_o pulses high for 1 cycle, in the cycle after the request. load_data_o holds its last value while load_valid_o is 0.
- Back-to-back requests on consecutive cycles are supported at full throughput with no stall.
- Input latency, with gpio_i changing before edge E:
  - DATA_IN updates at E+SYNC_STAGES-1.
  - INT_PEND sets at E+SYNC_STAGES.
  - interrupt_o and interrupt_vector_o update at E+SYNC_STAGES+1.
- Clearing the last pending bit (or writing INT_EN=0) deasserts interrupt_o one cycle after the register update.
- An input held high at reset release produces a rise term. It cannot set pending, because INT_RISE is 0 from reset.

## Test plan
- Reset: hold rst_i 2 cycles with gpio_i='1 -> all outputs at reset values, DATA_IN reads 0x00 in the first cycle after release, INT_PEND reads 0.
- Output path: store 0x04 <= 0xA5, then 0x1C <= 0x02, then 0x20 <= 0x80, then 0x08 <= 0xFF -> gpio_o = 0xA5, 0xA7, 0x27 in turn; gpio_oe_o = 0xFF; store_done_o high one cycle after each request.
- Edge interrupt (SYNC_STAGES=2, CHANNELS=8): INT_RISE=0x08, INT_EN=0x08, gpio_i[3] 0->1 before edge E -> INT_PEND=0x08 at E+2, interrupt_o=1 and vector=3 at E+3. A W1C of 0x08 to 0x18 drops interrupt_o two cycles after the store request.
- Priority and masking: pending 0x30 with INT_EN=0x20 -> vector 5; set INT_EN=0x30 -> vector 4; a falling edge on pin 7 with INT_FALL=0 -> no pending.
- Collision: a W1C of bit 2 issued in the same cycle that a new rise on pin 2 is latched -> INT_PEND bit 2 stays 1. A simultaneous load and store to 0x04 -> the load returns the old value.
- Parameter sweep CHANNELS=1/32, SYNC_STAGES=3 -> bits at or above CHANNELS read 0, and latency grows by one cycle per extra synchroniser stage.

Source files
------------

// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO with input synchroniser, edge-detect pending bits and prioritised interrupt
module gpio_controller #(
   parameter int CHANNELS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                store_request_i,
   input  logic [5:0]          store_address_i,
   input  logic [31:0]         store_data_i,
   output logic                store_done_o,
   input  logic                load_request_i,
   input  logic [5:0]          load_address_i,
   output logic [31:0]         load_data_o,
   output logic                load_valid_o,
   input  logic [CHANNELS-1:0] gpio_i,
   output logic [CHANNELS-1:0] gpio_o,
   output logic [CHANNELS-1:0] gpio_oe_o,
   output logic                interrupt_o,
   output logic [7:0]          interrupt_vector_o
);
   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0] data_in, prev_q, data_out_q, out_en_q, int_en_q, int_rise_q, int_fall_q, int_pend_q;
   logic [CHANNELS-1:0] wdata, rise, fall, w1c, active;
   logic [3:0]          st_idx, ld_idx;
   logic [31:0]         rdata;
   logic [7:0]          vec;
   logic                unused;

   assign data_in   = sync_q[SYNC_STAGES-1];
   assign st_idx    = store_address_i[5:2];
   assign ld_idx    = load_address_i[5:2];
   assign wdata     = store_data_i[CHANNELS-1:0];
   assign rise      = data_in & ~prev_q;
   assign fall      = ~data_in & prev_q;
   assign w1c       = (store_request_i && st_idx == 4'd6) ? wdata : '0;
   assign active    = int_pend_q & int_en_q;
   assign gpio_o    = data_out_q;
   assign gpio_oe_o = out_en_q;
   assign unused    = ^{store_address_i[1:0], load_address_i[1:0], store_data_i};

   always_comb begin
      rdata = '0;
      rdata[CHANNELS-1:0] = ld_idx == 4'd0 ? data_in    :
                            ld_idx == 4'd1 ? data_out_q :
                            ld_idx == 4'd2 ? out_en_q   :
                            ld_idx == 4'd3 ? int_en_q   :
                            ld_idx == 4'd4 ? int_rise_q :
                            ld_idx == 4'd5 ? int_fall_q :
                            ld_idx == 4'd6 ? int_pend_q : '0;
      vec = 8'hFF;
      for (int i = CHANNELS - 1; i >= 0; i--) vec = active[i] ? 8'(i) : vec;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q             <= '0;
         prev_q             <= '0;
         data_out_q         <= '0;
         out_en_q           <= '0;
         int_en_q           <= '0;
         int_rise_q         <= '0;
         int_fall_q         <= '0;
         int_pend_q         <= '0;
         store_done_o       <= 1'b0;
         load_valid_o       <= 1'b0;
         load_data_o        <= '0;
         interrupt_o        <= 1'b0;
         interrupt_vector_o <= 8'hFF;
      end else begin
         sync_q             <= {sync_q[SYNC_STAGES-2:0], gpio_i};
         prev_q             <= data_in;
         int_pend_q         <= (int_pend_q & ~w1c) | (rise & int_rise_q) | (fall & int_fall_q);
         interrupt_o        <= |active;
         interrupt_vector_o <= vec;
         store_done_o       <= store_request_i;
         load_valid_o       <= load_request_i;
         if (load_request_i) load_data_o <= rdata;
         if (store_request_i) begin
            case (st_idx)
               4'd1:    data_out_q <= wdata;
               4'd2:    out_en_q   <= wdata;
               4'd3:    int_en_q   <= wdata;
               4'd4:    int_rise_q <= wdata;
               4'd5:    int_fall_q <= wdata;
               4'd7:    data_out_q <= data_out_q | wdata;
               4'd8:    data_out_q <= data_out_q & ~wdata;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gpio_controller.sv
// tb_gpio_controller: directed and randomized checks against a spec-level reference model
module tb_gpio_controller;
   localparam int CH = 8, SS = 2;
   localparam logic [31:0] MASK = 32'hFF;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, st_req = 1'b0, ld_req = 1'b0;
   logic [5:0]  st_addr = '0, ld_addr = '0;
   logic [31:0] st_data = '0;
   logic [7:0]  gpio_a = '0;
   logic [0:0]  gpio_b = '0;
   logic [31:0] gpio_c = '0;

   logic        done_a, valid_a, irq_a, done_b, valid_b, irq_b, done_c, valid_c, irq_c;
   logic [31:0] ld_a, ld_b, ld_c;
   logic [7:0]  go_a, oe_a, vec_a, vec_b, vec_c;
   logic [0:0]  go_b, oe_b;
   logic [31:0] go_c, oe_c;

   gpio_controller #(.CHANNELS(CH), .SYNC_STAGES(SS)) u_a (
      .clk_i(clk), .rst_i(rst), .store_request_i(st_req), .store_address_i(st_addr),
      .store_data_i(st_data), .store_done_o(done_a), .load_request_i(ld_req),
      .load_address_i(ld_addr), .load_data_o(ld_a), .load_valid_o(valid_a),
      .gpio_i(gpio_a), .gpio_o(go_a), .gpio_oe_o(oe_a), .interrupt_o(irq_a),
      .interrupt_vector_o(vec_a));

   gpio_controller #(.CHANNELS(1), .SYNC_STAGES(3)) u_b (
      .clk_i(clk), .rst_i(rst), .store_request_i(st_req), .store_address_i(st_addr),
      .store_data_i(st_data), .store_done_o(done_b), .load_request_i(ld_req),
      .load_address_i(ld_addr), .load_data_o(ld_b), .load_valid_o(valid_b),
      .gpio_i(gpio_b), .gpio_o(go_b), .gpio_oe_o(oe_b), .interrupt_o(irq_b),
      .interrupt_vector_o(vec_b));

   gpio_controller #(.CHANNELS(32), .SYNC_STAGES(2)) u_c (
      .clk_i(clk), .rst_i(rst), .store_request_i(st_req), .store_address_i(st_addr),
      .store_data_i(st_data), .store_done_o(done_c), .load_request_i(ld_req),
      .load_address_i(ld_addr), .load_data_o(ld_c), .load_valid_o(valid_c),
      .gpio_i(gpio_c), .gpio_o(go_c), .gpio_oe_o(oe_c), .interrupt_o(irq_c),
      .interrupt_vector_o(vec_c));

   int n_cmp = 0, n_err = 0;
   logic [31:0] m_out, m_oe, m_ien, m_rise, m_fall, m_pend, m_ld;
   logic        m_valid, m_done, m_irq;
   logic [7:0]  m_vec;
   logic [31:0] hist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [5:0] a, input logic [31:0] din);
      case (a[5:2])
         4'd0: return din;
         4'd1: return m_out;
         4'd2: return m_oe;
         4'd3: return m_ien;
         4'd4: return m_rise;
         4'd5: return m_fall;
         4'd6: return m_pend;
         default: return 32'h0;
      endcase
   endfunction

   // hist holds the gpio value sampled at each past edge; DATA_IN lags it by SS-1 edges
   task automatic model_step();
      logic [31:0] din, prv, act, w1c, d;
      if (rst) begin
         {m_out, m_oe, m_ien, m_rise, m_fall, m_pend, m_ld} = '0;
         {m_valid, m_done, m_irq} = '0;
         m_vec = 8'hFF;
         hist.delete();
         repeat (SS + 1) hist.push_back(32'h0);
      end else begin
         din = hist[hist.size() - SS];
         prv = hist[hist.size() - SS - 1];
         d   = st_data & MASK;
         m_valid = ld_req;
         if (ld_req) m_ld = m_read(ld_addr, din);
         m_done = st_req;
         act   = m_pend & m_ien;
         m_irq = act != 0;
         m_vec = (act == 0) ? 8'hFF : 8'($clog2(act & (~act + 32'd1)));
         w1c   = (st_req && st_addr[5:2] == 4'd6) ? d : 32'h0;
         m_pend = (m_pend & ~w1c) | (din & ~prv & m_rise) | (~din & prv & m_fall);
         if (st_req) begin
            case (st_addr[5:2])
               4'd1: m_out  = d;
               4'd2: m_oe   = d;
               4'd3: m_ien  = d;
               4'd4: m_rise = d;
               4'd5: m_fall = d;
               4'd7: m_out  = m_out | d;
               4'd8: m_out  = m_out & ~d;
               default: ;
            endcase
         end
         hist.push_back({24'h0, gpio_a});
         if (hist.size() > SS + 1) void'(hist.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("gpio_o", {24'h0, go_a}, m_out);
      chk("gpio_oe_o", {24'h0, oe_a}, m_oe);
      chk("store_done_o", {31'h0, done_a}, {31'h0, m_done});
      chk("load_valid_o", {31'h0, valid_a}, {31'h0, m_valid});
      chk("load_data_o", ld_a, m_ld);
      chk("interrupt_o", {31'h0, irq_a}, {31'h0, m_irq});
      chk("interrupt_vector_o", {24'h0, vec_a}, {24'h0, m_vec});
   endtask

   task automatic store(input logic [5:0] a, input logic [31:0] d);
      st_req = 1'b1; st_addr = a; st_data = d;
      tick();
      st_req = 1'b0;
   endtask

   task automatic load(input logic [5:0] a);
      ld_req = 1'b1; ld_addr = a;
      tick();
      ld_req = 1'b0;
   endtask

   int lat_b, lat_c;

   initial begin
      // reset with inputs high
      gpio_a = '1; gpio_b = '1; gpio_c = '1;
      tick(); tick();
      chk("rst_gpio_o", {24'h0, go_a}, 32'h0);
      chk("rst_oe", {24'h0, oe_a}, 32'h0);
      chk("rst_irq", {31'h0, irq_a}, 32'h0);
      chk("rst_vec", {24'h0, vec_a}, 32'hFF);
      chk("rst_valid", {31'h0, valid_a}, 32'h0);
      chk("rst_done", {31'h0, done_a}, 32'h0);
      rst = 1'b0;
      load(6'h00);
      chk("din_after_rst", ld_a, 32'h0);
      chk("din_valid", {31'h0, valid_a}, 32'h1);
      load(6'h18);
      chk("pend_after_rst", ld_a, 32'h0);
      gpio_a = '0; gpio_b = '0; gpio_c = '0;
      repeat (4) tick();

      // output path
      store(6'h04, 32'hA5);
      chk("out_a5", {24'h0, go_a}, 32'hA5);
      chk("done_pulse", {31'h0, done_a}, 32'h1);
      store(6'h1C, 32'h02);
      chk("out_set", {24'h0, go_a}, 32'hA7);
      store(6'h20, 32'h80);
      chk("out_clr", {24'h0, go_a}, 32'h27);
      store(6'h08, 32'hFF);
      chk("oe_ff", {24'h0, oe_a}, 32'hFF);
      tick();
      chk("done_low", {31'h0, done_a}, 32'h0);

      // rising edge on pin 3
      store(6'h10, 32'h08);
      store(6'h0C, 32'h08);
      gpio_a[3] = 1'b1;
      tick(); tick(); tick();
      chk("irq_not_yet", {31'h0, irq_a}, 32'h0);
      tick();
      chk("irq_edge", {31'h0, irq_a}, 32'h1);
      chk("vec_edge", {24'h0, vec_a}, 32'h3);
      load(6'h18);
      chk("pend_edge", ld_a, 32'h08);
      store(6'h18, 32'h08);
      chk("irq_hold", {31'h0, irq_a}, 32'h1);
      tick();
      chk("irq_cleared", {31'h0, irq_a}, 32'h0);

      // priority and masking
      store(6'h14, 32'h0);
      store(6'h10, 32'h30);
      store(6'h0C, 32'h20);
      gpio_a[5:4] = 2'b11;
      repeat (4) tick();
      chk("vec_masked", {24'h0, vec_a}, 32'h5);
      store(6'h0C, 32'h30);
      tick();
      chk("vec_prio", {24'h0, vec_a}, 32'h4);
      gpio_a[7] = 1'b1;
      repeat (4) tick();
      gpio_a[7] = 1'b0;
      repeat (4) tick();
      load(6'h18);
      chk("no_fall_pend", ld_a, 32'h30);

      // set wins over same-cycle W1C, and load-before-store
      store(6'h18, 32'h30);
      tick(); tick();
      store(6'h10, 32'h04);
      gpio_a[2] = 1'b1;
      tick(); tick();
      store(6'h18, 32'h04);
      load(6'h18);
      chk("collision_set_wins", ld_a, 32'h04);
      store(6'h18, 32'h04);
      load(6'h18);
      chk("w1c_clears", ld_a, 32'h0);
      st_req = 1'b1; st_addr = 6'h04; st_data = 32'h5A;
      ld_req = 1'b1; ld_addr = 6'h04;
      tick();
      st_req = 1'b0; ld_req = 1'b0;
      chk("rbw_load", ld_a, 32'h27);
      chk("rbw_store", {24'h0, go_a}, 32'h5A);

      // width and latency of other parameterisations
      store(6'h14, 32'h0);
      store(6'h10, 32'hFFFF_FFFF);
      store(6'h0C, 32'hFFFF_FFFF);
      store(6'h04, 32'hFFFF_FFFF);
      chk("ch1_out", {31'h0, go_b}, 32'h1);
      chk("ch32_out", go_c, 32'hFFFF_FFFF);
      load(6'h04);
      chk("ch1_read", ld_b, 32'h1);
      chk("ch32_read", ld_c, 32'hFFFF_FFFF);
      gpio_b = 1'b1; gpio_c = 32'h8000_0000;
      lat_b = 0; lat_c = 0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (irq_b && lat_b == 0) lat_b = n;
         if (irq_c && lat_c == 0) lat_c = n;
      end
      chk("lat_sync3", lat_b, 32'd5);
      chk("lat_sync2", lat_c, 32'd4);
      chk("vec_ch1", {24'h0, vec_b}, 32'h0);
      chk("vec_ch32", {24'h0, vec_c}, 32'd31);
      load(6'h00);
      chk("din_ch1", ld_b, 32'h1);
      chk("din_ch32", ld_c, 32'h8000_0000);

      // reset during an access
      rst = 1'b1; st_req = 1'b1; st_addr = 6'h04; st_data = 32'h0; ld_req = 1'b1; ld_addr = 6'h04;
      tick();
      st_req = 1'b0; ld_req = 1'b0; rst = 1'b0;
      chk("rst_mid_done", {31'h0, done_a}, 32'h0);
      chk("rst_mid_valid", {31'h0, valid_a}, 32'h0);
      chk("rst_mid_out", {24'h0, go_a}, 32'h0);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         rst     = ($urandom_range(0, 199) == 0);
         st_req  = $urandom_range(0, 1) == 1;
         st_addr = {4'($urandom_range(0, 15)), 2'($urandom)};
         st_data = $urandom;
         ld_req  = $urandom_range(0, 1) == 1;
         ld_addr = {4'($urandom_range(0, 15)), 2'($urandom)};
         if ($urandom_range(0, 3) == 0) gpio_a = 8'($urandom);
         tick();
      end
      rst = 1'b0; st_req = 1'b0; ld_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
